// File: rtl/div_sequencer.sv
// Req/Ack front end for the shift/subtract divider: screens divide-by-zero and quotient overflow,
// launches the divider, waits for Done under a watchdog. Signed support is enabled by DIV_SIGNED_EN.
module div_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 40
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Req,
  input  logic               Signed,
  input  logic [2*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]   B,
  output logic               Ack,
  output logic               Busy,
  output logic               Valid,
  output logic [WIDTH-1:0]   Quotient,
  output logic [WIDTH-1:0]   Remainder,
  output logic               DivZero,
  output logic               Overflow,
  output logic               Timeout,
  output logic [2*WIDTH-1:0] Div_Dividend,
  output logic [WIDTH-1:0]   Div_Divisor,
  output logic               Div_Start,
  input  logic [WIDTH-1:0]   Div_Quotient,
  input  logic [WIDTH-1:0]   Div_Remainder,
  input  logic               Div_Done
);

  localparam int            DW  = 2 * WIDTH;
  localparam int            CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qraw_q, qraw_d;
  logic [WIDTH-1:0] rraw_q, rraw_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             divz_q, divz_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [DW-1:0]    mag_a;
  logic [WIDTH-1:0] mag_b;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] QMIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  logic sgn_q, sgn_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic neg_a, neg_b;
  logic fix_ovf;

  // Operand magnitudes and the signed range test on the divider's magnitude quotient.
  always_comb begin
    neg_a   = sgn_q & a_q[DW-1];
    neg_b   = sgn_q & b_q[WIDTH-1];
    mag_a   = neg_a ? (~a_q + 1'b1) : a_q;
    mag_b   = neg_b ? (~b_q + 1'b1) : b_q;
    fix_ovf = qneg_q ? (qraw_q > QMIN_MAG) : qraw_q[WIDTH-1];
  end
`else
  logic unused_signed;

  assign unused_signed = Signed;
  assign mag_a         = a_q;
  assign mag_b         = b_q;
`endif

  // Next-state and datapath update for the request sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    qraw_d  = qraw_q;
    rraw_d  = rraw_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    divz_d  = divz_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          a_d     = A;
          b_d     = B;
`ifdef DIV_SIGNED_EN
          sgn_d   = Signed;
`endif
          quot_d  = '0;
          rem_d   = '0;
          divz_d  = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (b_q == '0) begin
          divz_d  = 1'b1;
          state_d = S_DONE;
        end else if (mag_a[DW-1:WIDTH] >= mag_b) begin
          // Upper half not below the divisor: the quotient cannot fit in WIDTH bits.
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dvd_d   = mag_a;
          dvs_d   = mag_b;
`ifdef DIV_SIGNED_EN
          qneg_d  = neg_a ^ neg_b;
          rneg_d  = neg_a;
`endif
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A Done seen while the counter is still zero is left over from the previous operation.
        if ((cnt_q != '0) && Div_Done) begin
          qraw_d  = Div_Quotient;
          rraw_d  = Div_Remainder;
          state_d = S_FIX;
        end else if (cnt_q == TMO) begin
          tmo_d   = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_FIX: begin
`ifdef DIV_SIGNED_EN
        if (fix_ovf) begin
          ovf_d  = 1'b1;
          quot_d = '0;
          rem_d  = '0;
        end else begin
          quot_d = qneg_q ? (~qraw_q + 1'b1) : qraw_q;
          rem_d  = rneg_q ? (~rraw_q + 1'b1) : rraw_q;
        end
`else
        quot_d = qraw_q;
        rem_d  = rraw_q;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      qraw_q  <= '0;
      rraw_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      qraw_q  <= qraw_d;
      rraw_q  <= rraw_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
`ifdef DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  // Ack lands in the capturing IDLE cycle itself, so it is decoded from Req rather than registered.
  assign Ack          = ResetN & Req & (state_q == S_IDLE);
  assign Busy         = (state_q != S_IDLE);
  assign Valid        = (state_q == S_DONE);
  assign Div_Start    = (state_q == S_LAUNCH);
  assign Quotient     = quot_q;
  assign Remainder    = rem_q;
  assign DivZero      = divz_q;
  assign Overflow     = ovf_q;
  assign Timeout      = tmo_q;
  assign Div_Dividend = dvd_q;
  assign Div_Divisor  = dvs_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus randomized requests against
// an arithmetic reference model, with a behavioural divider that leaves a stale Done high.
module tb_div_sequencer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 40;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Req;
  logic        Signed;
  logic [15:0] A;
  logic [7:0]  B;
  logic        Ack, Busy, Valid;
  logic [7:0]  Quotient, Remainder;
  logic        DivZero, Overflow, Timeout;
  logic [15:0] Div_Dividend;
  logic [7:0]  Div_Divisor;
  logic        Div_Start;

  logic        div_done_m = 1'b0;
  logic [7:0]  dq_m = 8'h00;
  logic [7:0]  dr_m = 8'h00;
  logic [7:0]  pq = 8'h00;
  logic [7:0]  pr = 8'h00;
  int          mcnt = 0;
  bit          mclr = 1'b0;
  int          model_lat = 2;
  bit          done_en = 1'b1;

  int          checks = 0;
  int          errors = 0;
  bit          have_prev = 1'b0;
  logic [7:0]  prev_q, prev_r;
  logic [2:0]  prev_f;

  div_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .ResetN(ResetN), .Req(Req), .Signed(Signed), .A(A), .B(B),
    .Ack(Ack), .Busy(Busy), .Valid(Valid), .Quotient(Quotient), .Remainder(Remainder),
    .DivZero(DivZero), .Overflow(Overflow), .Timeout(Timeout),
    .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor), .Div_Start(Div_Start),
    .Div_Quotient(dq_m), .Div_Remainder(dr_m), .Div_Done(div_done_m)
  );

  initial forever #5 Clock = ~Clock;

  // Divider model: Done first high model_lat cycles after Start, held until one cycle after the next Start.
  always @(posedge Clock) begin
    if (Div_Start) begin
      mcnt <= model_lat - 1;
      mclr <= 1'b1;
      pq   <= 8'(Div_Dividend / Div_Divisor);
      pr   <= 8'(Div_Dividend % Div_Divisor);
    end else begin
      if (mclr) begin
        div_done_m <= 1'b0;
        mclr       <= 1'b0;
      end
      if (mcnt == 1 && done_en) begin
        div_done_m <= 1'b1;
        dq_m       <= pq;
        dr_m       <= pr;
      end
      if (mcnt > 0) mcnt <= mcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [15:0] a, input logic [7:0] b, input bit sgn,
                                    input int lat, input bit den,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output bit dz, output bit ov, output bit to, output int vcyc,
                                    output bit launched, output logic [15:0] ma_o, output logic [7:0] mb_o);
    bit s;
    int ai, bi, ma, mb, qi, ri;
    s  = sgn && SIGNED_EN;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    ma = (ai < 0) ? -ai : ai;
    mb = (bi < 0) ? -bi : bi;
    ma_o = 16'(ma);
    mb_o = 8'(mb);
    q = 8'h00; r = 8'h00; dz = 1'b0; ov = 1'b0; to = 1'b0; launched = 1'b0;
    if (bi == 0) begin
      dz = 1'b1; vcyc = 2;
    end else if ((ma / (1 << WIDTH)) >= mb) begin
      ov = 1'b1; vcyc = 2;
    end else begin
      launched = 1'b1;
      if (!den) begin
        to = 1'b1; vcyc = 4 + TIMEOUT;
      end else begin
        vcyc = 5 + (lat - 1);
        qi = ai / bi;
        ri = ai % bi;
        if (s && (qi < -128 || qi > 127)) begin
          ov = 1'b1;
        end else begin
          q = qi[7:0];
          r = ri[7:0];
        end
      end
    end
  endfunction

  task automatic check_reset(input string tag);
    check(tag, {Ack, Busy, Valid, Div_Start, DivZero, Overflow, Timeout,
                Quotient, Remainder, Div_Dividend, Div_Divisor}, 64'h0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit sgn,
                        input int lat, input bit den, input bit hold);
    logic [7:0]  eq, er, emb;
    logic [15:0] ema;
    bit          edz, eov, eto, launched;
    int          vexp, c, vcyc, nstart, scyc;
    bit          got_valid, busy_bad, ack_bad, opnd_bad;
    ref_model(a, b, sgn, lat, den, eq, er, edz, eov, eto, vexp, launched, ema, emb);
    @(negedge Clock);
    Req = 1'b1; A = a; B = b; Signed = sgn; done_en = den; model_lat = lat;
    #1;
    if (have_prev)
      check("held", {Quotient, Remainder, DivZero, Overflow, Timeout, Valid, Busy},
                    {prev_q, prev_r, prev_f, 2'b00});
    check("ack", Ack, 1'b1);
    c = 0; vcyc = -1; nstart = 0; scyc = -1;
    got_valid = 1'b0; busy_bad = 1'b0; ack_bad = 1'b0; opnd_bad = 1'b0;
    while (!got_valid && c < TIMEOUT + 12) begin
      @(negedge Clock);
      c++;
      if (c == 1) begin
        A = 16'($urandom); B = 8'($urandom); Signed = 1'($urandom);
        if (!hold) Req = 1'b0;
      end
      #1;
      if (Busy !== (c <= vexp)) busy_bad = 1'b1;
      if (Ack !== 1'b0) ack_bad = 1'b1;
      if (Div_Start === 1'b1) begin nstart++; scyc = c; end
      if (launched && c >= 2 && c <= vexp - 2 && (Div_Dividend !== ema || Div_Divisor !== emb))
        opnd_bad = 1'b1;
      if (Valid === 1'b1) begin got_valid = 1'b1; vcyc = c; end
    end
    check("valid_cycle", vcyc, vexp);
    check("start_count", nstart, launched ? 1 : 0);
    if (launched) begin
      check("start_cycle", scyc, 2);
      check("operands", opnd_bad, 1'b0);
    end
    check("busy", busy_bad, 1'b0);
    check("ack_quiet", ack_bad, 1'b0);
    check("quotient", Quotient, eq);
    check("remainder", Remainder, er);
    check("flags", {DivZero, Overflow, Timeout}, {edz, eov, eto});
    prev_q = eq; prev_r = er; prev_f = {edz, eov, eto}; have_prev = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb, hi;
    int          sel;
    ResetN = 1'b0; Req = 1'b0; Signed = 1'b0; A = 16'h0000; B = 8'h00;
    repeat (3) @(negedge Clock);
    #1;
    check_reset("reset_state");
    ResetN = 1'b1;

    run_op(16'd1000, 8'd7, 1'b0, 10, 1'b1, 1'b0);
    run_op(16'h1234, 8'd0, 1'b0, 5, 1'b1, 1'b0);
    run_op(16'h0100, 8'd1, 1'b0, 5, 1'b1, 1'b0);
    run_op(16'h00FF, 8'd1, 1'b0, 3, 1'b1, 1'b0);
    run_op(16'd1000, 8'd7, 1'b0, 5, 1'b0, 1'b0);
    run_op(16'd1000, 8'd9, 1'b0, 6, 1'b1, 1'b1);
    run_op(16'hFFFF, 8'hFF, 1'b0, 2, 1'b1, 1'b0);
    run_op(16'hFF9C, 8'd7, 1'b1, 4, 1'b1, 1'b0);
    run_op(16'hFC00, 8'hFC, 1'b1, 4, 1'b1, 1'b0);
    run_op(16'hFF80, 8'hFF, 1'b1, 7, 1'b1, 1'b0);
    run_op(16'hFF80, 8'h01, 1'b1, 3, 1'b1, 1'b0);

    // Reset in the middle of WAIT, then a fresh request with a stale Done from the aborted op.
    @(negedge Clock);
    Req = 1'b1; A = 16'd5000; B = 8'd50; Signed = 1'b0; done_en = 1'b1; model_lat = 15;
    @(negedge Clock);
    Req = 1'b0;
    repeat (4) @(negedge Clock);
    #1;
    check("busy_mid_wait", Busy, 1'b1);
    ResetN = 1'b0;
    @(negedge Clock);
    #1;
    check_reset("reset_mid_wait");
    ResetN = 1'b1;
    repeat (20) @(negedge Clock);
    have_prev = 1'b0;
    run_op(16'd5000, 8'd49, 1'b0, 6, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rb  = 8'($urandom);
      if (sel == 0) rb = 8'h00;
      hi  = (rb == 8'h00) ? 8'h00 : 8'($urandom_range(0, int'(rb) - 1));
      ra  = (sel <= 2) ? 16'($urandom) : {hi, 8'($urandom)};
      run_op(ra, rb, 1'($urandom), $urandom_range(2, 20), (sel != 9), (i < 39) ? 1'($urandom) : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Front-end controller for the 8-bit calculator's shift/subtract unsigned divider. It accepts a divide request over a Req/Ack handshake and screens out divide-by-zero and quotient overflow before launching. It then issues a single-cycle Start to the divider, waits for Done under a watchdog, and applies optional sign correction. Sits between the calculator's operation decoder and the divider datapath; the divider itself is unchanged.

## Interface
- WIDTH, 8: divisor/quotient/remainder width; dividend is 2*WIDTH.
- TIMEOUT, 40: maximum WAIT cycles before abort; must be ≥ 2*WIDTH+4.
- Clock  in  1  sole clock, rising edge.
- ResetN  in  1  synchronous, active-low reset.
- Req  in  1  request; sampled only in IDLE.
- Signed  in  1  operands are two's complement; used only with DIV_SIGNED_EN.
- A  in  2*WIDTH  dividend.
- B  in  WIDTH  divisor.
- Ack  out  1  one-cycle pulse when a request is captured.
- Busy  out  1  high in every state except IDLE.
- Valid  out  1  one-cycle pulse: result and flags final.
- Quotient, Remainder  out  WIDTH each  result, held until the next Ack.
- DivZero, Overflow, Timeout  out  1 each  error flags, held until the next Ack.
- Div_Dividend  out  2*WIDTH, Div_Divisor  out  WIDTH  operand magnitudes to the divider.
- Div_Start  out  1  divider start.
- Div_Quotient, Div_Remainder  in  WIDTH each; Div_Done  in  1  from the divider.

## Operation
- States: IDLE, CHECK, LAUNCH, WAIT, FIX, DONE.
- IDLE: Req=1 → capture A, B and Signed into internal registers; pulse Ack; clear Quotient, Remainder and all flags; go to CHECK. Req is ignored in every other state; there is no queuing.
- CHECK: compute magnitudes mA and mB; these are the raw values when unsigned.
  - B==0 → set DivZero, go to DONE.
  - mA[2W-1:W] ≥ mB → set Overflow (the quotient would not fit in WIDTH bits), go to DONE.
  - Otherwise → go to LAUNCH.
- LAUNCH: Div_Start=1 for exactly this cycle; go to WAIT. Div_Dividend and Div_Divisor are driven from LAUNCH through WAIT and are stable throughout.
- WAIT: a watchdog counter increments each cycle. Div_Done is ignored in the first WAIT cycle because a stale Done from the previous operation may still be high.
  - Div_Done=1 → capture Div_Quotient and Div_Remainder, go to FIX.
  - Counter reaches TIMEOUT → set Timeout, force results to 0, go to DONE.
- FIX: apply sign correction (see Configuration) and the signed overflow check; go to DONE.
- DONE: Valid=1; go to IDLE.
- Flags are mutually exclusive. When any flag is set, Quotient and Remainder are 0.
- Unsigned arithmetic: Quotient = floor(A/B), Remainder = A mod B. Both are passed through from the divider unchanged.

## Timing
- Reset (ResetN=0 at a Clock edge): state goes to IDLE; Ack, Busy, Valid, Div_Start, all flags, Quotient, Remainder and Div_* outputs go to 0; the watchdog clears. Reset applies from any state, including mid-WAIT.
- The divider is left un-sequenced after a reset. The next LAUNCH restarts it.
- Request accepted at cycle 0:
  - Ack in cycle 0.
  - CHECK in cycle 1.
  - Div_Start in cycle 2.
  - WAIT from cycle 3.
  - If Done is first seen in cycle 3+k (k≥1): FIX in cycle 4+k, Valid in cycle 5+k.
- Error in CHECK: Valid in cycle 2 and Div_Start never asserts.
- Timeout: Valid in cycle 4+TIMEOUT.
- Busy rises in cycle 1 and falls after DONE. The earliest next Ack is the cycle after Valid.
- Req held high continuously: back-to-back operations, with one IDLE cycle between each.

## Configuration
- DIV_SIGNED_EN defined: with Signed=1, A and B are two's complement.
  - Magnitudes are sent to the divider.
  - Quotient sign is sign(A)^sign(B); Remainder takes the sign of A (truncating division).
  - FIX sets Overflow if the signed quotient falls outside [-2^(W-1), 2^(W-1)-1].
  - With Signed=0, behaviour is unsigned.
- DIV_SIGNED_EN undefined: Signed is ignored, all operations are unsigned, and no negate logic is synthesized.

## Test plan
- A=1000, B=7, unsigned, Div_Done model asserts 10 cycles after Start → Quotient=142 (0x8E), Remainder=6, no flags; Valid exactly once, in cycle 5+k.
- A=0x1234, B=0 → DivZero=1, Quotient=Remainder=0, Valid in cycle 2, Div_Start never high.
- A=0x0100, B=1 → Overflow=1 in CHECK, Valid in cycle 2. A=0x00FF, B=1 → Quotient=255, Remainder=0.
- Div_Done held low, TIMEOUT=40 → Timeout=1, Valid in cycle 44. A second request, now with Done working, completes normally.
- DIV_SIGNED_EN, Signed=1, A=-100 (0xFF9C), B=7 → Quotient=0xF2 (-14), Remainder=0xFE (-2). A=-1024, B=-4 → Overflow=1 (quotient 256).
- ResetN=0 during WAIT → all outputs 0 on the next edge, state IDLE. A fresh request then gives correct results, with stale Done high in the first WAIT cycle ignored.
